// File: rtl/fsm_table_sequencer_if.sv
// Host-side bundle for the table-driven FSM sequencer: table programming, run control,
// symbol stream in, FSM output and status out.
interface fsm_table_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             stop;
  logic             cfg_wr;
  logic [4:0]       cfg_addr;
  logic [5:0]       cfg_data;
  logic             cfg_ack;
  logic             cfg_err;
  logic             sym_valid;
  logic [1:0]       sym;
  logic             sym_ready;
  logic             out_valid;
  logic [2:0]       out;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, cfg_wr, cfg_addr, cfg_data, sym_valid, sym,
    input  cfg_ack, cfg_err, sym_ready, out_valid, out, state_o, step_cnt, busy, done
  );

  modport slave (
    input  start, stop, cfg_wr, cfg_addr, cfg_data, sym_valid, sym,
    output cfg_ack, cfg_err, sym_ready, out_valid, out, state_o, step_cnt, busy, done
  );
endinterface

// File: rtl/fsm_table_sequencer.sv
// Table-driven 8-state FSM controller: owns the 32x6 transition RAM, accepts programming outside RUN,
// steps once per accepted symbol; out/out_valid follow an accept by 1 cycle, sym_ready only in RUN.
module fsm_table_sequencer #(
  parameter logic [2:0] INIT_STATE = 3'd0,
  parameter int         MAX_STEPS  = 16,
  parameter int         CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_table_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_STEPS - 1);

  ctrl_t      ctrl, ctrl_nxt;
  logic [5:0] ram [32];
  logic       accept;
  logic       start_run;
  logic       wr_ok;
  logic       wr_rej;
  logic [5:0] entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctrl <= IDLE;
    else        ctrl <= ctrl_nxt;
  end

  // stop overrides everything, including a simultaneous start
  always_comb begin
    ctrl_nxt = ctrl;
    if (bus.stop) begin
      ctrl_nxt = IDLE;
    end else begin
      case (ctrl)
        IDLE:    if (bus.start) ctrl_nxt = RUN;
        RUN:     if (accept && bus.step_cnt == LAST) ctrl_nxt = DONE;
        DONE:    if (bus.start) ctrl_nxt = RUN;
        default: ctrl_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sym_ready = (ctrl == RUN);
    bus.busy      = (ctrl == RUN);
    bus.done      = (ctrl == DONE);
    accept        = bus.sym_valid && (ctrl == RUN) && !bus.stop;
    start_run     = bus.start && !bus.stop && (ctrl != RUN);
    wr_ok         = bus.cfg_wr && (ctrl != RUN);
    wr_rej        = bus.cfg_wr && (ctrl == RUN);
    entry         = ram[{bus.state_o, bus.sym}];
  end

  // table contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (reset && wr_ok) ram[bus.cfg_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.state_o   <= INIT_STATE;
      bus.out       <= 3'd0;
      bus.step_cnt  <= '0;
      bus.out_valid <= 1'b0;
      bus.cfg_ack   <= 1'b0;
      bus.cfg_err   <= 1'b0;
    end else begin
      bus.cfg_ack   <= wr_ok;
      bus.cfg_err   <= wr_rej;
      bus.out_valid <= accept;
      if (start_run) begin
        bus.state_o  <= INIT_STATE;
        bus.step_cnt <= '0;
      end else if (accept) begin
        bus.state_o  <= entry[5:3];
        bus.out      <= entry[2:0];
        bus.step_cnt <= bus.step_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Drives two sequencers (MAX_STEPS 16 and 4) with identical stimulus and checks both every cycle
// against a per-instance reference model plus directed expectations.
module tb_fsm_table_sequencer;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start, stop, cfg_wr, sym_valid;
  logic [4:0] cfg_addr;
  logic [5:0] cfg_data;
  logic [1:0] sym;

  fsm_table_sequencer_if #(.CNT_W(CW)) ifa ();
  fsm_table_sequencer_if #(.CNT_W(CW)) ifb ();

  assign ifa.start = start;         assign ifb.start = start;
  assign ifa.stop = stop;           assign ifb.stop = stop;
  assign ifa.cfg_wr = cfg_wr;       assign ifb.cfg_wr = cfg_wr;
  assign ifa.cfg_addr = cfg_addr;   assign ifb.cfg_addr = cfg_addr;
  assign ifa.cfg_data = cfg_data;   assign ifb.cfg_data = cfg_data;
  assign ifa.sym_valid = sym_valid; assign ifb.sym_valid = sym_valid;
  assign ifa.sym = sym;             assign ifb.sym = sym;

  fsm_table_sequencer #(.INIT_STATE(3'd0), .MAX_STEPS(16), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  fsm_table_sequencer #(.INIT_STATE(3'd0), .MAX_STEPS(4), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  logic [5:0]  ctl_act [2];
  logic [10:0] dat_act [2];
  assign ctl_act[0] = {ifa.sym_ready, ifa.busy, ifa.done, ifa.out_valid, ifa.cfg_ack, ifa.cfg_err};
  assign ctl_act[1] = {ifb.sym_ready, ifb.busy, ifb.done, ifb.out_valid, ifb.cfg_ack, ifb.cfg_err};
  assign dat_act[0] = {ifa.out, ifa.state_o, ifa.step_cnt};
  assign dat_act[1] = {ifb.out, ifb.state_o, ifb.step_cnt};

  int vectors = 0;
  int miscompares = 0;

  // reference model: mode 0=idle 1=run 2=done
  int max_s [2] = '{16, 4};
  int m_mode [2], m_state [2], m_out [2], m_cnt [2];
  bit m_ov [2], m_ack [2], m_err [2];
  int tbl [2][32];

  int seq  [9] = '{1, 1, 2, 2, 1, 2, 0, 3, 3};
  int eout [9] = '{2, 4, 7, 1, 3, 2, 0, 5, 6};
  int ps   [9] = '{0, 2, 4, 7, 1, 3, 2, 0, 5};
  int pa   [9] = '{1, 1, 2, 2, 1, 2, 0, 3, 3};
  int pn   [9] = '{2, 4, 7, 1, 3, 2, 0, 5, 6};
  int ov_count;

  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_state[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
      m_ov[i] = 1'b0; m_ack[i] = 1'b0; m_err[i] = 1'b0;
    end
  endfunction

  function automatic void mdl_step();
    for (int i = 0; i < 2; i++) begin
      int  e, nm;
      bit  acc;
      acc = (m_mode[i] == 1) && sym_valid && !stop;
      m_ack[i] = cfg_wr && (m_mode[i] != 1);
      m_err[i] = cfg_wr && (m_mode[i] == 1);
      m_ov[i]  = acc;
      if (stop)                nm = 0;
      else if (m_mode[i] == 1) nm = (acc && m_cnt[i] == max_s[i] - 1) ? 2 : 1;
      else                     nm = start ? 1 : m_mode[i];
      if (m_mode[i] != 1 && start && !stop) begin
        m_state[i] = 0;
        m_cnt[i]   = 0;
      end else if (acc) begin
        e = tbl[i][m_state[i] * 4 + int'(sym)];
        m_state[i] = e / 8;
        m_out[i]   = e % 8;
        m_cnt[i]++;
      end
      if (cfg_wr && m_mode[i] != 1) tbl[i][cfg_addr] = int'(cfg_data);
      m_mode[i] = nm;
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [5:0]  ce;
      logic [10:0] de;
      ce = {m_mode[i] == 1, m_mode[i] == 1, m_mode[i] == 2, m_ov[i], m_ack[i], m_err[i]};
      de = {3'(m_out[i]), 3'(m_state[i]), 5'(m_cnt[i])};
      vectors++;
      assert (ctl_act[i] === ce) else begin
        miscompares++;
        $error("FAIL ctl dut%0d observed=%b expected=%b", i, ctl_act[i], ce);
      end
      vectors++;
      assert (dat_act[i] === de) else begin
        miscompares++;
        $error("FAIL data dut%0d observed=%h expected=%h", i, dat_act[i], de);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (!reset) mdl_reset();
    else        mdl_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    start = 0; stop = 0; cfg_wr = 0; sym_valid = 0;
    cfg_addr = '0; cfg_data = '0; sym = '0;
  endtask

  task automatic run_stream();
    ov_count = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 9; k++) begin
      sym_valid = 1; sym = 2'(seq[k]);
      tick();
      if (ifa.out_valid) ov_count++;
      chk("out_seq", int'(ifa.out), eout[k]);
      if (k == 3) chk("b_ready_after_max", int'(ifb.sym_ready), 0);
    end
    sym_valid = 0;
    tick();
    chk("ov_count", ov_count, 9);
    chk("step_cnt_a", int'(ifa.step_cnt), 9);
    chk("state_a", int'(ifa.state_o), 6);
    chk("done_b", int'(ifb.done), 1);
    chk("step_cnt_b", int'(ifb.step_cnt), 4);
    chk("out_b", int'(ifb.out), 1);
  endtask

  initial begin
    idle_in();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) tbl[i][a] = 0;

    reset = 0;
    repeat (2) tick();
    chk("rst_state", int'(ifa.state_o), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    reset = 1;
    repeat (3) tick();

    // fill every entry so random symbols never hit an unwritten slot
    for (int a = 0; a < 32; a++) begin
      cfg_wr = 1; cfg_addr = 5'(a); cfg_data = 6'($urandom);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      cfg_wr = 1; cfg_addr = 5'(ps[k] * 4 + pa[k]); cfg_data = 6'(pn[k] * 9);
      tick();
      chk("cfg_ack", int'(ifa.cfg_ack), 1);
      chk("cfg_err", int'(ifa.cfg_err), 0);
    end
    cfg_wr = 0;
    tick();

    run_stream();

    start = 1; tick(); start = 0;
    cfg_wr = 1; cfg_addr = 5'd1; cfg_data = 6'h3f;
    tick();
    cfg_wr = 0;
    chk("cfg_err_run", int'(ifa.cfg_err), 1);
    chk("cfg_ack_run", int'(ifa.cfg_ack), 0);
    stop = 1; tick(); stop = 0;
    run_stream();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_stop_busy", int'(ifa.busy), 0);
    chk("start_stop_done", int'(ifb.done), 0);

    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      sym_valid = 1; sym = 2'(seq[k]);
      tick();
    end
    sym = 2'(seq[3]);
    reset = 0;
    #1;
    chk("midrst_state", int'(ifa.state_o), 0);
    chk("midrst_out", int'(ifa.out), 0);
    chk("midrst_busy", int'(ifa.busy), 0);
    chk("midrst_cnt", int'(ifa.step_cnt), 0);
    mdl_reset();
    tick();
    reset = 1; sym_valid = 0;
    tick();
    run_stream();

    for (int n = 0; n < 600; n++) begin
      start     = ($urandom_range(15) == 0);
      stop      = ($urandom_range(31) == 0);
      cfg_wr    = ($urandom_range(7) == 0);
      cfg_addr  = 5'($urandom);
      cfg_data  = 6'($urandom);
      sym_valid = ($urandom_range(3) != 0);
      sym       = 2'($urandom);
      tick();
    end
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
